regfile_sb: RTL and testbench

Parametrised integer register file with a per-register busy scoreboard and optional write-to-read bypass. It is the next-generation replacement for the CPU's single-write register file and sits between the decode stage and the write-back stage. Decode reserves a destination register when it issues a multi-cycle operation, such as a load that enters MEM_WAIT. Write-back releases the reservation and can forward the result to the read ports in the same cycle.

---
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register busy scoreboard and
// optional same-cycle write-to-read bypass.
//   i_clk, i_rst          : clock (rising edge), asynchronous active-high reset
//   i_state               : CPU state; writes commit in WRITE_BACK, reserves in DECODE
//   i_rs1/i_rs2           : read addresses -> o_rs1_val/o_rs2_val, o_rs1_busy/o_rs2_busy
//   i_rd/i_result         : write address/data, qualified by i_reg_write
//   i_resv_valid/i_resv_rd: reservation request for a destination register
//   i_dbg_addr -> o_dbg_val: stored value only, never bypassed
//   o_pending             : number of busy registers
//   o_resv_err            : sticky flag, set when a busy register is reserved again
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_state,
  input  logic [AW-1:0]   i_rs1,
  input  logic [AW-1:0]   i_rs2,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  input  logic [AW-1:0]   i_rd,
  input  logic [XLEN-1:0] i_result,
  input  logic            i_reg_write,
  input  logic            i_resv_valid,
  input  logic [AW-1:0]   i_resv_rd,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_val,
  output logic [AW:0]     o_pending,
  output logic            o_resv_err
);

  // Storage spans the full address space so every address indexes cleanly;
  // entries at or above NREGS are never written and never read out.
  localparam int unsigned DEPTH         = 1 << AW;
  localparam logic [2:0]  ST_DECODE     = 3'b001;
  localparam logic [2:0]  ST_WRITE_BACK = 3'b011;

  logic [XLEN-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_pending;
  logic             r_resv_err;

  logic             w_we;
  logic             w_re;
  logic             w_set;
  logic             w_clr;
  logic             w_byp1;
  logic             w_byp2;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      w_pending_nxt;

  // Architectural, non-x0 register address.
  function automatic logic writable(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREGS);
  endfunction

  // Enables, next busy vector and pending delta.
  always_comb begin
    w_we  = i_reg_write && (i_state == ST_WRITE_BACK) && writable(i_rd);
    w_re  = i_resv_valid && (i_state == ST_DECODE) && writable(i_resv_rd);
    w_set = w_re && !r_busy[i_resv_rd];
    // A clear overridden by a same-register reserve leaves the bit set.
    w_clr = w_we && r_busy[i_rd] && !(w_re && (i_resv_rd == i_rd));
    w_busy_nxt = r_busy;
    if (w_we) w_busy_nxt[i_rd] = 1'b0;
    if (w_re) w_busy_nxt[i_resv_rd] = 1'b1;
    w_pending_nxt = r_pending + (AW+1)'(w_set) - (AW+1)'(w_clr);
  end

  // Combinational read ports with optional forwarding of the committing write.
  always_comb begin
    o_rs1_val  = '0;
    o_rs2_val  = '0;
    o_rs1_busy = 1'b0;
    o_rs2_busy = 1'b0;
    o_dbg_val  = '0;
    w_byp1 = (BYPASS != 0) && w_we && (i_rs1 == i_rd);
    w_byp2 = (BYPASS != 0) && w_we && (i_rs2 == i_rd);
    if (writable(i_rs1)) begin
      o_rs1_val  = w_byp1 ? i_result : r_regs[i_rs1];
      o_rs1_busy = r_busy[i_rs1] && !w_byp1;
    end
    if (writable(i_rs2)) begin
      o_rs2_val  = w_byp2 ? i_result : r_regs[i_rs2];
      o_rs2_busy = r_busy[i_rs2] && !w_byp2;
    end
    if (writable(i_dbg_addr)) begin
      o_dbg_val = r_regs[i_dbg_addr];
    end
  end

  // State: register contents, scoreboard, counter, sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_pending  <= '0;
      r_resv_err <= 1'b0;
    end else begin
      if (w_we) r_regs[i_rd] <= i_result;
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
      if (w_re && r_busy[i_resv_rd]) r_resv_err <= 1'b1;
    end
  end

  assign o_pending  = r_pending;
  assign o_resv_err = r_resv_err;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                         S_WB = 3'd3, S_MEMWAIT = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [4:0]  rs1, rs2, rd, resv_rd, dbg_addr;
  logic [31:0] result;
  logic        reg_write, resv_valid;

  // Instance a: NREGS=16, BYPASS=1. Instance b: NREGS=32, BYPASS=0.
  logic [31:0] rs1_val_a, rs2_val_a, dbg_val_a, rs1_val_b, rs2_val_b, dbg_val_b;
  logic        rs1_busy_a, rs2_busy_a, err_a, rs1_busy_b, rs2_busy_b, err_b;
  logic [5:0]  pending_a, pending_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .AW(5), .NREGS(16), .BYPASS(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_state(state), .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_val(rs1_val_a), .o_rs2_val(rs2_val_a), .o_rs1_busy(rs1_busy_a),
    .o_rs2_busy(rs2_busy_a), .i_rd(rd), .i_result(result), .i_reg_write(reg_write),
    .i_resv_valid(resv_valid), .i_resv_rd(resv_rd), .i_dbg_addr(dbg_addr),
    .o_dbg_val(dbg_val_a), .o_pending(pending_a), .o_resv_err(err_a));

  regfile_sb #(.XLEN(32), .AW(5), .NREGS(32), .BYPASS(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_state(state), .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_val(rs1_val_b), .o_rs2_val(rs2_val_b), .o_rs1_busy(rs1_busy_b),
    .o_rs2_busy(rs2_busy_b), .i_rd(rd), .i_result(result), .i_reg_write(reg_write),
    .i_resv_valid(resv_valid), .i_resv_rd(resv_rd), .i_dbg_addr(dbg_addr),
    .o_dbg_val(dbg_val_b), .o_pending(pending_b), .o_resv_err(err_b));

  // Reference model: architectural contents, busy set and error flag per instance.
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];
  bit          m_err  [2];

  function automatic int nregs(input int k);
    return (k == 0) ? 16 : 32;
  endfunction

  function automatic bit m_we(input int k);
    return reg_write && state == S_WB && rd != 0 && int'(rd) < nregs(k);
  endfunction

  function automatic bit m_re(input int k);
    return resv_valid && state == S_DECODE && resv_rd != 0 && int'(resv_rd) < nregs(k);
  endfunction

  function automatic logic [31:0] m_val(input int k, input logic [4:0] a);
    if (a == 0 || int'(a) >= nregs(k)) return 32'd0;
    if (k == 0 && m_we(k) && a == rd) return result;
    return m_regs[k][a];
  endfunction

  function automatic bit m_bsy(input int k, input logic [4:0] a);
    if (a == 0 || int'(a) >= nregs(k)) return 1'b0;
    if (k == 0 && m_we(k) && a == rd) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [31:0] m_dbg(input int k, input logic [4:0] a);
    if (a == 0 || int'(a) >= nregs(k)) return 32'd0;
    return m_regs[k][a];
  endfunction

  function automatic int m_pending(input int k);
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[k][i]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = 32'd0;
        m_busy[k][i] = 1'b0;
      end
    end
  endtask

  task automatic m_commit();
    for (int k = 0; k < 2; k++) begin
      bit we = m_we(k);
      bit re = m_re(k);
      bit was_busy = m_busy[k][resv_rd];
      if (we) begin
        m_regs[k][rd] = result;
        m_busy[k][rd] = 1'b0;
      end
      if (re) begin
        if (was_busy) m_err[k] = 1'b1;
        m_busy[k][resv_rd] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, " a.rs1_val"},  64'(rs1_val_a),  64'(m_val(0, rs1)));
    check({tag, " a.rs2_val"},  64'(rs2_val_a),  64'(m_val(0, rs2)));
    check({tag, " a.rs1_busy"}, 64'(rs1_busy_a), 64'(m_bsy(0, rs1)));
    check({tag, " a.rs2_busy"}, 64'(rs2_busy_a), 64'(m_bsy(0, rs2)));
    check({tag, " a.dbg_val"},  64'(dbg_val_a),  64'(m_dbg(0, dbg_addr)));
    check({tag, " a.pending"},  64'(pending_a),  64'(m_pending(0)));
    check({tag, " a.resv_err"}, 64'(err_a),      64'(m_err[0]));
    check({tag, " b.rs1_val"},  64'(rs1_val_b),  64'(m_val(1, rs1)));
    check({tag, " b.rs2_val"},  64'(rs2_val_b),  64'(m_val(1, rs2)));
    check({tag, " b.rs1_busy"}, 64'(rs1_busy_b), 64'(m_bsy(1, rs1)));
    check({tag, " b.rs2_busy"}, 64'(rs2_busy_b), 64'(m_bsy(1, rs2)));
    check({tag, " b.dbg_val"},  64'(dbg_val_b),  64'(m_dbg(1, dbg_addr)));
    check({tag, " b.pending"},  64'(pending_b),  64'(m_pending(1)));
    check({tag, " b.resv_err"}, 64'(err_b),      64'(m_err[1]));
  endtask

  task automatic set_in(input logic [2:0] st, input logic wr, input logic [4:0] d,
                        input logic [31:0] res, input logic rv, input logic [4:0] r,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    state = st; reg_write = wr; rd = d; result = res;
    resv_valid = rv; resv_rd = r; rs1 = a1; rs2 = a2; dbg_addr = ad;
  endtask

  task automatic idle(input logic [4:0] a);
    set_in(S_FETCH, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a, a, a);
  endtask

  // Mid-cycle check of combinational outputs, then the edge commits.
  task automatic settle(input string tag);
    #4;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    #1;
    m_reset();
    check_all(tag);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle(5'd0);
    m_reset();
    #1 rst = 1'b1;
    #1 check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset clears written data immediately.
    set_in(S_WB, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5);
    settle("wb x5");
    check("bypass x5 a", 64'(rs1_val_a), 64'h0000_0000_DEAD_BEEF);
    tick();
    idle(5'd5);
    #1 check("x5 stored b", 64'(rs1_val_b), 64'h0000_0000_DEAD_BEEF);
    pulse_rst("rst pulse");
    check("x5 after rst", 64'(rs1_val_a), 64'd0);
    check("pending after rst", 64'(pending_a), 64'd0);

    // Write gating by state and x0.
    set_in(S_EXECUTE, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
    settle("wr exec"); tick();
    idle(5'd7);
    #1 check("x7 gated", 64'(rs1_val_a), 64'd0);
    set_in(S_WB, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
    settle("wr wb"); tick();
    idle(5'd7);
    #1 check("x7 written", 64'(rs1_val_b), 64'h1234_5678);
    set_in(S_WB, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    settle("wr x0"); tick();
    idle(5'd0);
    #1 check("x0 zero", 64'(rs1_val_a), 64'd0);

    // Reserve and release x3.
    set_in(S_DECODE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3);
    settle("resv x3"); tick();
    idle(5'd3);
    #1 check("x3 busy", 64'(rs1_busy_a), 64'd1);
    check("pending 1", 64'(pending_a), 64'd1);
    set_in(S_WB, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd3, 5'd3);
    settle("rel x3");
    check("x3 bypass val a", 64'(rs1_val_a), 64'h0000_0000_A5A5_A5A5);
    check("x3 bypass busy a", 64'(rs1_busy_a), 64'd0);
    check("x3 old val b", 64'(rs1_val_b), 64'd0);
    check("x3 old busy b", 64'(rs1_busy_b), 64'd1);
    tick();
    idle(5'd3);
    #1 check("x3 new val b", 64'(rs1_val_b), 64'h0000_0000_A5A5_A5A5);
    check("pending 0", 64'(pending_a), 64'd0);

    // Double reserve of x9; error stays after release.
    set_in(S_DECODE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9);
    settle("resv9 #1"); tick();
    settle("resv9 #2"); tick();
    idle(5'd9);
    #1 check("dbl err", 64'(err_a), 64'd1);
    check("dbl pending", 64'(pending_a), 64'd1);
    set_in(S_WB, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
    settle("rel x9"); tick();
    idle(5'd9);
    #1 check("err sticky", 64'(err_a), 64'd1);

    // Out-of-range reserve/read on the 16-register instance.
    set_in(S_DECODE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd20, 5'd20, 5'd20);
    settle("resv 20"); tick();
    idle(5'd20);
    #1 check("oor pending", 64'(pending_a), 64'd0);
    check("oor read", 64'(rs1_val_a), 64'd0);
    for (int i = 1; i < 16; i++) begin
      set_in(S_DECODE, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'd20, 5'(i));
      settle("resv fill"); tick();
    end
    idle(5'd1);
    #1 check("pending 15", 64'(pending_a), 64'd15);
    for (int i = 1; i < 16; i++) begin
      set_in(S_WB, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 5'(i), 5'(16 - i), 5'(i));
      settle("wb drain"); tick();
    end
    idle(5'd1);
    #1 check("pending drained", 64'(pending_a), 64'd0);

    // Randomised traffic with occasional asynchronous resets.
    pulse_rst("rst pre-random");
    for (int n = 0; n < 400; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
         : (($urandom_range(0, 1) == 1) ? S_DECODE : S_WB);
      if (n % 7 == 0) st = S_MEMWAIT;
      set_in(st, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)),
             5'($urandom_range(0, 19)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (n % 61 == 60) pulse_rst("rst random");
      settle("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
